// File: rtl/csmulti_arbiter_pkg.sv
// csmulti_arbiter_pkg
// Shared definitions for the time-shared carry-save multiplier arbiter:
//   - state_e : FSM state encoding (IDLE=0, CALC=1, RESP=2)
//   - clog2   : index width helper (at least 1 bit)
package csmulti_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Ceiling log2 with a floor of one bit so a requester index always has a width.
    function automatic int clog2(input int value);
        int width;
        width = 32'sd1;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                width = (i + 32'sd1 > width) ? i + 32'sd1 : width;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/csmulti_fullbasecell.sv
// csmulti_fullbasecell
// Purely combinational unsigned multiplier built from a carry-save adder
// array: each partial product row is folded into a sum/carry pair with a
// 3:2 compressor and a single carry-propagate add resolves the final result.
// Ports:
//   a, b    : bitsize-wide unsigned factors
//   product : 2*bitsize-wide exact unsigned product
module csmulti_fullbasecell #(
    parameter int bitsize = 8
) (
    input  logic [bitsize-1:0]   a,
    input  logic [bitsize-1:0]   b,
    output logic [2*bitsize-1:0] product
);

    logic [2*bitsize-1:0] sum_s;
    logic [2*bitsize-1:0] carry_s;
    logic [2*bitsize-1:0] pp_s;
    logic [2*bitsize-1:0] nsum_s;
    logic [2*bitsize-1:0] ncarry_s;

    // Carry-save accumulation of partial products, then final resolve add.
    // The true product fits 2*bitsize bits, so modular truncation of the
    // intermediate vectors still yields the exact result.
    always_comb begin
        sum_s    = '0;
        carry_s  = '0;
        pp_s     = '0;
        nsum_s   = '0;
        ncarry_s = '0;
        for (int i = 0; i < bitsize; i++) begin
            pp_s     = ({{bitsize{1'b0}}, b} & {(2*bitsize){a[i]}}) << i;
            nsum_s   = sum_s ^ carry_s ^ pp_s;
            ncarry_s = ((sum_s & carry_s) | (sum_s & pp_s) | (carry_s & pp_s)) << 1;
            sum_s    = nsum_s;
            carry_s  = ncarry_s;
        end
        product = sum_s + carry_s;
    end

endmodule

// File: rtl/csmulti_arbiter.sv
// csmulti_arbiter
// Shares one carry-save multiplier among nreq requesters using a round-robin
// picker and an IDLE -> CALC -> RESP FSM. One request is in flight at a time.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req_valid / req_ready  : per-requester operand handshake (ready one-hot)
//   req_a / req_b          : packed operands, requester r at [r*bitsize +: bitsize]
//   resp_valid / resp_ready: result handshake
//   resp_id, resp_product  : owner index and exact unsigned product
//   busy                   : high whenever the FSM is not IDLE
module csmulti_arbiter
    import csmulti_arbiter_pkg::*;
#(
    parameter int bitsize = 8,
    parameter int nreq    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [nreq-1:0]          req_valid,
    output logic [nreq-1:0]          req_ready,
    input  logic [nreq*bitsize-1:0]  req_a,
    input  logic [nreq*bitsize-1:0]  req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [clog2(nreq)-1:0]   resp_id,
    output logic [2*bitsize-1:0]     resp_product,
    output logic                     busy
);

    localparam int idw = clog2(nreq);

    state_e               state_q, state_d;
    logic [idw-1:0]       last_grant_q, last_grant_d;
    logic [bitsize-1:0]   op_a_q, op_a_d;
    logic [bitsize-1:0]   op_b_q, op_b_d;
    logic [idw-1:0]       op_id_q, op_id_d;
    logic [2*bitsize-1:0] result_q, result_d;
    logic [idw-1:0]       resp_id_q, resp_id_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 busy_q, busy_d;

    logic                 found_s;
    logic [idw-1:0]       grant_idx_s;
    logic [nreq-1:0]      req_ready_s;
    logic                 handshake_s;
    logic [bitsize-1:0]   sel_a_s;
    logic [bitsize-1:0]   sel_b_s;
    logic [2*bitsize-1:0] mult_s;

    csmulti_fullbasecell #(
        .bitsize (bitsize)
    ) u_mult (
        .a       (op_a_q),
        .b       (op_b_q),
        .product (mult_s)
    );

    // Round-robin picker: scan from last_grant+1, wrapping, first valid wins.
    always_comb begin
        int             cand;
        logic [idw-1:0] cand_idx;
        found_s     = 1'b0;
        grant_idx_s = '0;
        cand        = 32'sd0;
        cand_idx    = '0;
        for (int k = 1; k <= nreq; k++) begin
            cand     = (int'(last_grant_q) + k) % nreq;
            cand_idx = idw'(cand);
            if (!found_s && req_valid[cand_idx]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_idx;
            end else begin
                found_s     = found_s;
            end
        end
        if (found_s && (state_q == ST_IDLE) && !rst) begin
            req_ready_s = {{(nreq-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            req_ready_s = '0;
        end
    end

    assign handshake_s = |req_ready_s;

    // Operand mux for the winning requester.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int r = 0; r < nreq; r++) begin
            if (int'(grant_idx_s) == r) begin
                sel_a_s = req_a[r*bitsize +: bitsize];
                sel_b_s = req_b[r*bitsize +: bitsize];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        result_d     = result_q;
        resp_id_d    = resp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_d      = ST_CALC;
                    last_grant_d = grant_idx_s;
                    op_a_d       = sel_a_s;
                    op_b_d       = sel_b_s;
                    op_id_d      = grant_idx_s;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_CALC: begin
                // Operands have been stable for the whole cycle; capture the product.
                state_d   = ST_RESP;
                result_d  = mult_s;
                resp_id_d = op_id_q;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        resp_valid_d = (state_d == ST_RESP);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= idw'(nreq - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= '0;
            result_q     <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            result_q     <= result_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready    = req_ready_s;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_product = result_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_csmulti_arbiter.sv
// tb_csmulti_arbiter
// Directed stimulus with a response scoreboard: each issued request pushes its
// expected {id, product}; a monitor pops and compares on every resp handshake.
module tb_csmulti_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [15:0] resp_product;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    csmulti_arbiter #(
        .bitsize (8),
        .nreq    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Scoreboard monitor: compare every accepted response against the queue head.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got id %0d product 0x%0h, required no response",
                         resp_id, resp_product);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_id", {30'd0, resp_id}, {30'd0, mon_e[17:16]});
                check("resp_product", {16'd0, resp_product}, {16'd0, mon_e[15:0]});
            end
        end
    end

    task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b);
        req_valid[r[1:0]] = 1'b1;
        req_a[r*8 +: 8]   = a;
        req_b[r*8 +: 8]   = b;
    endtask

    // Wait (bounded) for a grant, check it, and step past the handshake edge.
    task automatic take_grant(input string name, input logic [3:0] exp_onehot, output int gcyc);
        int k;
        k = 0;
        @(negedge clk);
        while (req_ready == 4'd0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check(name, {28'd0, req_ready}, {28'd0, exp_onehot});
        gcyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("return_to_idle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  ca [4];
        logic [7:0]  cb [4];
        logic [15:0] cp [4];
        int g;
        int prev_g;
        ca = '{8'd3, 8'd5, 8'd7, 8'd9};
        cb = '{8'd4, 8'd6, 8'd8, 8'd10};
        cp = '{16'd12, 16'd30, 16'd56, 16'd90};
        g = 0;
        prev_g = 0;

        // Reset with all requesters asserting: no ready may leak out.
        rst = 1'b1; req_valid = 4'hF; req_a = 32'd0; req_b = 32'd0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_product", {16'd0, resp_product}, 32'd0);
        check("rst_id", {30'd0, resp_id}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 4'd0; resp_ready = 1'b1;

        // Single request: 13*11 = 143, resp_valid two cycles after handshake.
        set_req(0, 8'd13, 8'd11);
        exp_q.push_back({2'd0, 16'd143});
        take_grant("grant_single", 4'b0001, g);
        req_valid = 4'd0;
        @(negedge clk);
        check("calc_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("calc_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("latency_resp_valid", {31'd0, resp_valid}, 32'd1);
        wait_idle();

        // Contention from reset: order 0,1,2,3,0 every 3 cycles.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int r = 0; r < 4; r++) set_req(r, ca[r], cb[r]);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({2'(i % 4), cp[i % 4]});
            take_grant($sformatf("grant_rr%0d", i), 4'b0001 << (i % 4), g);
            if (i > 0) check("grant_interval", g - prev_g, 32'd3);
            prev_g = g;
        end
        req_valid = 4'd0;
        wait_idle();

        // Backpressure on r2 (FF*FF), r1 waiting with 0*A5.
        resp_ready = 1'b0;
        set_req(2, 8'hFF, 8'hFF);
        exp_q.push_back({2'd2, 16'hFE01});
        take_grant("grant_bp", 4'b0100, g);
        req_valid = 4'd0;
        set_req(1, 8'h00, 8'hA5);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_product", {16'd0, resp_product}, 32'h0000_FE01);
            check("bp_id", {30'd0, resp_id}, 32'd2);
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        exp_q.push_back({2'd1, 16'h0000});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_busy", {31'd0, busy}, 32'd0);
        check("bp_release_ready", {28'd0, req_ready}, 32'h0000_0002);
        @(posedge clk);
        #1;
        req_valid = 4'd0;
        wait_idle();

        // Reset in the CALC cycle: result discarded, r0 first afterwards.
        set_req(3, 8'd7, 8'd7);
        take_grant("grant_pre_rst", 4'b1000, g);
        req_valid = 4'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
            check("rstmid_busy", {31'd0, busy}, 32'd0);
        end
        @(posedge clk);
        #1;
        set_req(0, 8'd20, 8'd12);
        set_req(1, 8'd1, 8'd1);
        set_req(2, 8'd1, 8'd1);
        set_req(3, 8'd1, 8'd1);
        exp_q.push_back({2'd0, 16'd240});
        take_grant("grant_after_rst", 4'b0001, g);
        req_valid = 4'd0;
        wait_idle();

        // Wrap: grant r3, then with r1 and r3 valid r1 must win.
        set_req(3, 8'd16, 8'd16);
        exp_q.push_back({2'd3, 16'd256});
        take_grant("grant_r3", 4'b1000, g);
        req_valid = 4'd0;
        wait_idle();
        set_req(1, 8'd200, 8'd3);
        set_req(3, 8'd2, 8'd2);
        exp_q.push_back({2'd1, 16'd600});
        take_grant("grant_wrap", 4'b0010, g);
        req_valid = 4'd0;
        wait_idle();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csmulti_arbiter.md
CSMULTI_ARBITER -- requirements
Module: csmulti_arbiter

Interface
REQ-001 Parameter bitsize, default 8, operand width in bits.
REQ-002 Parameter nreq, default 4, number of requesters (2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  nreq  per-requester operand-pair valid.
REQ-006 req_ready  output  nreq  per-requester accept; at most one bit set per cycle.
REQ-007 req_a  input  nreq*bitsize  packed factor0 operands; requester r at bits [r*bitsize +: bitsize].
REQ-008 req_b  input  nreq*bitsize  packed factor1 operands, packed the same way as req_a.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  result consumer accept.
REQ-011 resp_id  output  clog2(nreq)  index of the requester that owns resp_product.
REQ-012 resp_product  output  2*bitsize  unsigned product req_a*req_b.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The block SHALL time-share one combinational carry-save multiplier among nreq requesters.
REQ-015 FSM states SHALL be IDLE, CALC and RESP.
REQ-016 Transition IDLE->CALC on a handshake (req_valid[r] && req_ready[r]); otherwise remain in IDLE.
REQ-017 Transition CALC->RESP unconditionally after one cycle.
REQ-018 Transition RESP->IDLE on resp_ready; otherwise hold RESP.
REQ-019 req_ready SHALL be combinational, nonzero only in IDLE, and one-hot on the round-robin winner among set req_valid bits; zero when no req_valid is set.
REQ-020 Round-robin: search starts at (last_grant+1) mod nreq, wrapping; after a grant, last_grant SHALL update to the granted index.
REQ-021 On handshake, operands and requester index SHALL be latched into the operand registers that drive the multiplier.
REQ-022 In CALC, the multiplier output SHALL be captured into the result register; the multiplier is given a full cycle to settle.
REQ-023 resp_valid=1 throughout RESP; resp_product and resp_id SHALL stay stable until the resp_ready handshake.
REQ-024 Latency: handshake in cycle N gives resp_valid in cycle N+2; minimum issue interval is 3 cycles.
REQ-025 resp_product SHALL equal the exact unsigned product; no truncation, saturation or sign handling; all-ones operands give (2^bitsize-1)^2.
REQ-026 A requester not granted SHALL keep req_valid and its operands stable; the block SHALL not drop or reorder a granted request.
REQ-027 resp_ready asserted outside RESP SHALL be ignored.
REQ-028 A req_valid deasserted before grant SHALL simply not be granted, with no state change.

Reset
REQ-029 With rst high at a clock edge: state=IDLE, resp_valid=0, busy=0, resp_product=0, resp_id=0, operand registers=0, last_grant=nreq-1 so requester 0 has first priority.
REQ-030 req_ready SHALL be all-zero while rst is high.
REQ-031 Reset asserted mid-operation (CALC or RESP) SHALL discard the in-flight result; no resp_valid appears afterwards for that request.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE=0, CALC=1, RESP=2, 2 bits) and the index-width function clog2.
REQ-033 The datapath SHALL be one instance of the existing parameterized carry-save multiplier, csmulti_fullbasecell, with bitsize passed through; no other sub-module.
REQ-034 The round-robin picker SHALL be local combinational logic in csmulti_arbiter.

Verification
REQ-035 Single request: after reset, r0 requests a=8'd13, b=8'd11 -> req_ready[0] in the same cycle, resp_valid 2 cycles later, resp_product=16'd143, resp_id=0.
REQ-036 Contention: all four requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles, each resp_id matching its operands.
REQ-037 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_product and resp_id held, req_ready all-zero; releasing resp_ready gives IDLE next cycle.
REQ-038 Extremes: a=b=8'hFF -> 16'hFE01; a=0, b=8'hA5 -> 16'h0000.
REQ-039 Reset mid-CALC: rst pulsed in the cycle after the handshake -> resp_valid stays 0, busy=0, and the next grant goes to requester 0.
REQ-040 Wrap: last grant was r3 and r1 and r3 both valid -> r1 granted.
